// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one divider core between four requesters.
// Operands are latched at grant and held on the core ports until the result
// is captured; the winner receives a one-cycle ack with the result on the bus.
module div_share_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACCEPT_TO = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   dividend_in,
  input  logic [4*WIDTH-1:0]   divisor_in,
  output logic [3:0]           ack,
  output logic [WIDTH-1:0]     quotient_out,
  output logic [WIDTH-1:0]     remainder_out,
  output logic                 not_valid_out,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 div_strt,
  output logic [WIDTH-1:0]     div_dividend,
  output logic [WIDTH-1:0]     div_divisor,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic [WIDTH-1:0]     div_remainder,
  input  logic                 div_not_valid,
  input  logic                 div_idle
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNT_W = $clog2(ACCEPT_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         grant_q, grant_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               strt_q, strt_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               nv_q, nv_d;
  logic               pick_found;
  logic [1:0]         pick_idx;

  // Round-robin search starting just after the last-served requester
  always_comb begin
    logic [1:0] cand;
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = last_q;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = last_q + 2'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    strt_d  = 1'b0;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    nv_d    = nv_q;

    case (state_q)
      S_IDLE: begin
        // The ack cycle is spent in IDLE while the served requester still
        // holds req; arbitration resumes on the following cycle.
        if ((ack_q == '0) && pick_found && div_idle) begin
          grant_d = pick_idx;
          dvd_d   = dividend_in[32'(pick_idx)*WIDTH +: WIDTH];
          dvs_d   = divisor_in[32'(pick_idx)*WIDTH +: WIDTH];
          strt_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (!div_idle) begin
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(ACCEPT_TO)) begin
            quo_d   = div_quotient;
            rem_d   = div_remainder;
            nv_d    = div_not_valid;
            state_d = S_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        if (div_idle) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          nv_d    = div_not_valid;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack_d   = NREQ'(1) << grant_q;
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      grant_q <= '0;
      ack_q   <= '0;
      strt_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      strt_q  <= strt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      nv_q    <= nv_d;
    end
  end

  assign ack           = ack_q;
  assign quotient_out  = quo_q;
  assign remainder_out = rem_q;
  assign not_valid_out = nv_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign div_strt      = strt_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;

endmodule
